// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode values, FSM states, opcode helpers.
// No logic of its own; imported by the interface consumers, the top and the iterative datapath.
// Opcode values are those of the single-cycle ALU so the control unit encoding is unchanged.
package alu_pkg;

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_MUL  = 4'd3;
   localparam logic [3:0] ALU_PASS = 4'd4;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;
   localparam logic [3:0] ALU_MULU = 4'd13;
   localparam logic [3:0] ALU_DIV  = 4'd14;
   localparam logic [3:0] ALU_DIVU = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Ops that go through the WIDTH-step shift/add or shift/subtract datapath.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULU) || (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   function automatic logic is_divide(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   // Ops whose operands are interpreted as two's complement by the iterative datapath.
   function automatic logic is_signed_iter(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bundle between the execute-stage control and the multi-cycle ALU.
// master drives Start/AluOP/X/Y and observes Busy/Done/results/flags; slave is the ALU side.
// No buffering: a Start presented while Busy is high is simply not taken.
interface alu_mc_if #(parameter int WIDTH = 32);

   logic             Start;
   logic [3:0]       AluOP;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] Result_2;
   logic             Equal;
   logic             smaller;
   logic             bigger_equal;

   modport master (
      output Start, AluOP, X, Y,
      input  Busy, Done, Result, Result_2, Equal, smaller, bigger_equal
   );

   modport slave (
      input  Start, AluOP, X, Y,
      output Busy, Done, Result, Result_2, Equal, smaller, bigger_equal
   );

endinterface

// File: rtl/alu_mc_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract step per step tick.
// Latency: WIDTH step ticks after load; res_lo/res_hi are the sign-corrected results once last has been stepped.
// No backpressure: load/step are commanded by the owning FSM; x/y are only sampled on load.
// Ports: clk/tick/reset, load (capture operands), step (one iteration), op (selects mul/div and signedness),
//        x/y operands, last (counter at final step), res_lo/res_hi (product halves or quotient/remainder).
module alu_mc_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             tick,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             last,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CW = $clog2(WIDTH) + 1;

   // acc is one bit wider than an operand: the multiply carry and the shifted partial remainder need it.
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] mq;      // multiplier / dividend, becomes product low half / quotient
   logic [WIDTH-1:0] opb;     // multiplicand / divisor magnitude
   logic [CW-1:0]    cnt;
   logic             div_mode;
   logic             neg_q;   // negate product or quotient
   logic             neg_r;   // negate remainder (takes sign of X)
   logic             div0;

   logic             sx;
   logic             sy;
   logic [WIDTH-1:0] mag_x;
   logic [WIDTH-1:0] mag_y;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shl;
   logic             fits;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Magnitudes at load time; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
   always_comb begin
      sx    = is_signed_iter(op) & x[WIDTH-1];
      sy    = is_signed_iter(op) & y[WIDTH-1];
      mag_x = sx ? -x : x;
      mag_y = sy ? -y : y;
   end

   always_comb begin
      add_sum = mq[0] ? (acc + {1'b0, opb}) : acc;
      shl     = {acc[WIDTH-1:0], mq[WIDTH-1]};
      fits    = (shl >= {1'b0, opb});
   end

   assign last = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (tick) begin
         if (reset) begin
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
         end else if (load) begin
            acc      <= '0;
            mq       <= mag_x;
            opb      <= mag_y;
            cnt      <= CW'(WIDTH);
            div_mode <= is_divide(op);
            neg_q    <= sx ^ sy;
            neg_r    <= sx;
            div0     <= (y == '0);
         end else if (step) begin
            cnt <= cnt - CW'(1);
            if (div_mode) begin
               if (fits) begin
                  acc <= shl - {1'b0, opb};
                  mq  <= {mq[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= shl;
                  mq  <= {mq[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= {1'b0, add_sum[WIDTH:1]};
               mq  <= {add_sum[0], mq[WIDTH-1:1]};
            end
         end
      end
   end

   // Sign correction. Divide by zero forces an all-ones quotient regardless of sign; the remainder path
   // already yields X because the unsigned core returns the dividend magnitude for a zero divisor.
   always_comb begin
      prod     = {acc[WIDTH-1:0], mq};
      prod_fix = neg_q ? -prod : prod;
      quo      = div0 ? '1 : (neg_q ? -mq : mq);
      rem      = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_lo   = div_mode ? quo : prod_fix[WIDTH-1:0];
      res_hi   = div_mode ? rem : prod_fix[2*WIDTH-1:WIDTH];
   end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative mul/div with remainder.
// Latency: results one tick after accept for single-cycle ops; Busy for WIDTH+1 ticks then Done for mul/div.
// Backpressure: Busy high means Start is ignored (not queued); the pipeline must stall and re-issue.
// Ports: LOGISIM_CLOCK_TREE_0 (bit 4 = clock edge, bit 2 = tick enable), Reset (sync, active high),
//        bus (slave side of alu_mc_if: Start/AluOP/X/Y in, Busy/Done/Result/Result_2/flags out).
//        WIDTH must be a power of two and at least 8.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [4:0] LOGISIM_CLOCK_TREE_0,
   input  logic       Reset,
   alu_mc_if.slave    bus
);

   localparam int SHW = $clog2(WIDTH);

   logic clk;
   logic tick;
   logic unused_tree;

   assign clk         = LOGISIM_CLOCK_TREE_0[4];
   assign tick        = LOGISIM_CLOCK_TREE_0[2];
   assign unused_tree = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

   state_t state;
   state_t state_nxt;

   logic accept;
   logic launch;
   logic step;
   logic finish;
   logic iter_last;

   logic [WIDTH-1:0] iter_lo;
   logic [WIDTH-1:0] iter_hi;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_res2;
   logic             sc_smaller;
   logic             lt_s;
   logic             lt_u;
   logic             eq_now;

   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result2_q;
   logic             equal_q;
   logic             smaller_q;
   logic             done_q;
   logic             pend_equal;  // Equal of the accepted operands, held until the iterative op completes

   assign shamt  = bus.Y[SHW-1:0];
   assign eq_now = (bus.X == bus.Y);

   // Single-cycle results, evaluated on the live operands and registered at the accept tick.
   always_comb begin
      sc_res     = '0;
      sc_res2    = '0;
      sc_smaller = 1'b0;
      lt_s       = ($signed(bus.X) < $signed(bus.Y));
      lt_u       = (bus.X < bus.Y);
      case (bus.AluOP)
         ALU_SLL:  sc_res = bus.X << shamt;
         ALU_SRA:  sc_res = $signed(bus.X) >>> shamt;
         ALU_SRL:  sc_res = bus.X >> shamt;
         ALU_PASS: begin
            sc_res  = bus.X;
            sc_res2 = bus.Y;
         end
         ALU_ADD:  sc_res = bus.X + bus.Y;
         ALU_SUB:  sc_res = bus.X - bus.Y;
         ALU_AND:  sc_res = bus.X & bus.Y;
         ALU_OR:   sc_res = bus.X | bus.Y;
         ALU_XOR:  sc_res = bus.X ^ bus.Y;
         ALU_NOR:  sc_res = ~(bus.X | bus.Y);
         ALU_SLT: begin
            sc_smaller = lt_s;
            sc_res     = {{(WIDTH-1){1'b0}}, lt_s};
         end
         ALU_SLTU: begin
            sc_smaller = lt_u;
            sc_res     = {{(WIDTH-1){1'b0}}, lt_u};
         end
         default: ;
      endcase
   end

   // FSM: IDLE accepts everything; single-cycle ops never leave IDLE so they can issue back to back.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      launch    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.Start) begin
               accept = 1'b1;
               if (is_iterative(bus.AluOP)) begin
                  launch    = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (iter_last) begin
               state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tick) begin
         if (Reset) begin
            state <= ST_IDLE;
         end else begin
            state <= state_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tick) begin
         if (Reset) begin
            result_q   <= '0;
            result2_q  <= '0;
            equal_q    <= 1'b0;
            smaller_q  <= 1'b0;
            done_q     <= 1'b0;
            pend_equal <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (accept && !launch) begin
               result_q  <= sc_res;
               result2_q <= sc_res2;
               equal_q   <= eq_now;
               smaller_q <= sc_smaller;
               done_q    <= 1'b1;
            end else if (finish) begin
               result_q  <= iter_lo;
               result2_q <= iter_hi;
               equal_q   <= pend_equal;
               smaller_q <= 1'b0;
               done_q    <= 1'b1;
            end
            if (launch) begin
               pend_equal <= eq_now;
            end
         end
      end
   end

   alu_mc_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .tick   (tick),
      .reset  (Reset),
      .load   (launch),
      .step   (step),
      .op     (bus.AluOP),
      .x      (bus.X),
      .y      (bus.Y),
      .last   (iter_last),
      .res_lo (iter_lo),
      .res_hi (iter_hi)
   );

   assign bus.Busy         = (state != ST_IDLE);
   assign bus.Done         = done_q;
   assign bus.Result       = result_q;
   assign bus.Result_2     = result2_q;
   assign bus.Equal        = equal_q;
   assign bus.smaller      = smaller_q;
   assign bus.bigger_equal = ~smaller_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random ops against an arithmetic reference model.
// Inputs are driven 1 time unit after each rising clock edge; outputs are sampled at the same point.
// Bounded waits throughout; every comparison goes through check().
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic       clk4;
   logic       tick_en;
   logic       rst;
   wire  [4:0] clk_tree;

   int n_assert = 0;
   int n_fail   = 0;

   assign clk_tree = {clk4, 1'b0, tick_en, 2'b00};

   alu_mc_if #(.WIDTH(W)) bus ();

   alu_mc #(.WIDTH(W)) dut (
      .LOGISIM_CLOCK_TREE_0 (clk_tree),
      .Reset                (rst),
      .bus                  (bus)
   );

   initial clk4 = 1'b0;
   always #5 clk4 = ~clk4;

   task automatic tick();
      @(posedge clk4);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: results straight from the arithmetic definition of each opcode.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [W-1:0] r2,
                                 output logic eq, output logic sm);
      longint      sa;
      longint      sb;
      longint      q;
      longint      m;
      logic [63:0] p;
      int          sh;
      sa = $signed(a);
      sb = $signed(b);
      sh = int'(b[4:0]);
      r  = '0;
      r2 = '0;
      sm = 1'b0;
      eq = (a == b);
      case (op)
         4'd0:  r = a << sh;
         4'd1:  r = $signed(a) >>> sh;
         4'd2:  r = a >> sh;
         4'd3:  begin p = sa * sb; r = p[31:0]; r2 = p[63:32]; end
         4'd4:  begin r = a; r2 = b; end
         4'd5:  r = a + b;
         4'd6:  r = a - b;
         4'd7:  r = a & b;
         4'd8:  r = a | b;
         4'd9:  r = a ^ b;
         4'd10: r = ~(a | b);
         4'd11: begin sm = (sa < sb); r = {31'b0, sm}; end
         4'd12: begin sm = (a < b); r = {31'b0, sm}; end
         4'd13: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; r2 = p[63:32]; end
         4'd14: begin
            if (b == 0) begin
               r = '1; r2 = a;
            end else begin
               q = sa / sb; m = sa % sb;
               r = q[31:0]; r2 = m[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               r = '1; r2 = a;
            end else begin
               r = a / b; r2 = a % b;
            end
         end
      endcase
   endfunction

   function automatic int exp_ticks(input logic [3:0] op);
      return (op == 4'd3 || op >= 4'd13) ? W + 1 : 0;
   endfunction

   task automatic check_outputs(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
      logic [W-1:0] er;
      logic [W-1:0] er2;
      logic         eeq;
      logic         esm;
      model(op, a, b, er, er2, eeq, esm);
      check({tag, ".Result"},   bus.Result, er);
      check({tag, ".Result_2"}, bus.Result_2, er2);
      check({tag, ".Equal"},    bus.Equal, eeq);
      check({tag, ".smaller"},  bus.smaller, esm);
      check({tag, ".bigger"},   bus.bigger_equal, !esm);
   endtask

   // Issue one op, scramble the operands after accept, wait for Done and check everything.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int           lat;
      int           busy_n;
      logic [W-1:0] held;
      bus.Start = 1'b1;
      bus.AluOP = op;
      bus.X     = a;
      bus.Y     = b;
      tick();
      bus.Start = 1'b0;
      bus.AluOP = 4'($urandom);
      bus.X     = $urandom;
      bus.Y     = $urandom;
      lat    = 0;
      busy_n = 0;
      while (!bus.Done && lat < 100) begin
         if (bus.Busy) busy_n++;
         tick();
         lat++;
      end
      check({tag, ".done_ticks"}, lat, exp_ticks(op));
      check({tag, ".busy_ticks"}, busy_n, exp_ticks(op) == 0 ? 0 : W + 1);
      check({tag, ".busy_at_done"}, bus.Busy, 1'b0);
      check_outputs(tag, op, a, b);
      held = bus.Result;
      tick();
      check({tag, ".done_pulse"}, bus.Done, 1'b0);
      check({tag, ".hold"}, bus.Result, held);
   endtask

   initial begin
      int           lat;
      int           dones;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;

      rst       = 1'b1;
      tick_en   = 1'b1;
      bus.Start = 1'b0;
      bus.AluOP = '0;
      bus.X     = '0;
      bus.Y     = '0;
      repeat (3) tick();
      check("rst.Busy",     bus.Busy, 1'b0);
      check("rst.Done",     bus.Done, 1'b0);
      check("rst.Result",   bus.Result, 0);
      check("rst.Result_2", bus.Result_2, 0);
      check("rst.Equal",    bus.Equal, 1'b0);
      check("rst.smaller",  bus.smaller, 1'b0);
      check("rst.bigger",   bus.bigger_equal, 1'b1);
      rst = 1'b0;
      tick();

      // Directed cases from the arithmetic corners.
      run_op("add",     ALU_ADD,  32'd5, 32'd7);
      check("add.const", bus.Result, 32'd12);
      run_op("slt",     ALU_SLT,  32'hFFFF_FFFF, 32'd1);
      run_op("sltu",    ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
      run_op("mul",     ALU_MUL,  -32'sd3, 32'd5);
      check("mul.const", {bus.Result_2, bus.Result}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("mulu",    ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mulu.const", {bus.Result_2, bus.Result}, 64'hFFFF_FFFE_0000_0001);
      run_op("divu",    ALU_DIVU, 32'd100, 32'd7);
      run_op("div",     ALU_DIV,  -32'sd7, 32'd2);
      check("div.const", {bus.Result_2, bus.Result}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_ovf", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div0s",   ALU_DIV,  -32'sd9, 32'd0);
      run_op("divu0",   ALU_DIVU, 32'd9, 32'd0);
      run_op("sra",     ALU_SRA,  32'h8000_00F0, 32'd36);
      run_op("eq",      ALU_PASS, 32'h1234_5678, 32'h1234_5678);
      run_op("mul_eq",  ALU_MUL,  32'h8000_0000, 32'h8000_0000);

      // Random ops over all opcodes with biased operand choices.
      for (int i = 0; i < 48; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       b = $urandom_range(0, 40);
            1:       b = 32'd0;
            2:       b = 32'hFFFF_FFFF;
            3:       b = a;
            default: b = $urandom;
         endcase
         run_op("rand", op, a, b);
      end

      // Back-to-back single-cycle ops: one result per tick while Start stays high.
      bus.Start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op = (i == 0) ? ALU_SUB : (i == 1) ? ALU_NOR : (i == 2) ? ALU_SLL : ALU_SLTU;
         a  = $urandom;
         b  = $urandom;
         bus.AluOP = op;
         bus.X     = a;
         bus.Y     = b;
         tick();
         check("b2b.Done", bus.Done, 1'b1);
         check_outputs("b2b", op, a, b);
      end
      bus.Start = 1'b0;
      tick();

      // DIV by zero with an ADD issued mid-run: the ADD is dropped.
      bus.Start = 1'b1;
      bus.AluOP = ALU_DIV;
      bus.X     = 32'd9;
      bus.Y     = 32'd0;
      tick();
      bus.Start = 1'b0;
      lat = 0;
      while (!bus.Done && lat < 100) begin
         if (lat == 10) begin
            bus.Start = 1'b1;
            bus.AluOP = ALU_ADD;
            bus.X     = 32'd1;
            bus.Y     = 32'd2;
         end else begin
            bus.Start = 1'b0;
         end
         tick();
         lat++;
      end
      bus.Start = 1'b0;
      check("ign.done_ticks", lat, W + 1);
      check_outputs("ign", ALU_DIV, 32'd9, 32'd0);
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.Done) dones++;
      end
      check("ign.extra_done", dones, 0);

      // Tick enable low freezes the datapath: edges without a tick do not advance it.
      bus.Start = 1'b1;
      bus.AluOP = ALU_MULU;
      bus.X     = 32'd123457;
      bus.Y     = 32'd98765;
      tick();
      bus.Start = 1'b0;
      tick_en   = 1'b0;
      repeat (10) tick();
      check("gate.Busy", bus.Busy, 1'b1);
      check("gate.Done", bus.Done, 1'b0);
      tick_en = 1'b1;
      lat = 1;
      tick();
      while (!bus.Done && lat < 100) begin
         tick();
         lat++;
      end
      check("gate.done_ticks", lat, W + 1);
      check_outputs("gate", ALU_MULU, 32'd123457, 32'd98765);
      tick();

      // Reset in the middle of a MULU aborts with no Done.
      run_op("pre_rst", ALU_ADD, 32'd3, 32'd4);
      bus.Start = 1'b1;
      bus.AluOP = ALU_MULU;
      bus.X     = 32'hDEAD_BEEF;
      bus.Y     = 32'h1234_5678;
      tick();
      bus.Start = 1'b0;
      repeat (5) tick();
      check("mid.Busy_before", bus.Busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid.Busy",     bus.Busy, 1'b0);
      check("mid.Done",     bus.Done, 1'b0);
      check("mid.Result",   bus.Result, 0);
      check("mid.Result_2", bus.Result_2, 0);
      check("mid.Equal",    bus.Equal, 1'b0);
      check("mid.smaller",  bus.smaller, 1'b0);
      check("mid.bigger",   bus.bigger_equal, 1'b1);
      dones = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (bus.Done || bus.Busy) dones++;
      end
      check("mid.no_done", dones, 0);
      run_op("post_rst", ALU_ADD, 32'd1, 32'd1);
      check("post_rst.const", bus.Result, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, width-parametrised successor to the CPU's single-cycle ALU.
- Keeps the same 4-bit AluOP encoding and flag outputs.
- Adds full-width signed/unsigned multiply (high and low halves) and signed/unsigned divide with remainder, using an iterative datapath.
- Sits in the execute stage. The control unit issues Start and stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2 and at least 8.
- SHW, $clog2(WIDTH), local: shift-amount width taken from Y[SHW-1:0].

Ports:
- LOGISIM_CLOCK_TREE_0  in  5  clock tree; state updates on rising edge of bit 4, qualified by tick enable bit 2.
- Reset  in  1  synchronous, active-high.
- Start  in  1  issue request; operands and AluOP sampled when Start=1 and Busy=0.
- AluOP  in  4  operation select.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- Busy  out  1  iterative op in progress; new Start ignored.
- Done  out  1  one-tick pulse; Result, Result_2 and flags valid from this tick on.
- Result  out  WIDTH  primary result.
- Result_2  out  WIDTH  secondary result (product high half / remainder / Y).
- Equal  out  1  X==Y of the accepted operands.
- smaller  out  1  compare result for ops 11/12, else 0.
- bigger_equal  out  1  ~smaller.

Behaviour:
- Clocking: one clock, synchronous active-high Reset. All registers update only on ticks (edge of bit 4 with bit 2 = 1).
- Reset: Busy=0, Done=0, Result=0, Result_2=0, Equal=0, smaller=0, state IDLE. bigger_equal reads 1.
- Reset mid-operation aborts immediately to these values; no Done is produced.
- Opcodes. Result_2 = 0 unless stated otherwise:
  - 0 SLL
  - 1 SRA
  - 2 SRL
  - 3 MUL signed: Result=low half, Result_2=high half
  - 4 PASS: Result=X, Result_2=Y
  - 5 ADD (wraps, no carry out)
  - 6 SUB (wraps)
  - 7 AND
  - 8 OR
  - 9 XOR
  - 10 NOR
  - 11 SLT signed: Result=zero-extended compare bit
  - 12 SLTU unsigned: Result=zero-extended compare bit
  - 13 MULU unsigned: Result=low half, Result_2=high half
  - 14 DIV signed: Result=quotient, Result_2=remainder
  - 15 DIVU unsigned: Result=quotient, Result_2=remainder
- State machine: IDLE -> RUN -> FIX -> IDLE.
  - IDLE plus accepted single-cycle op (0-2, 4-12): results and flags registered at the accept tick; Done=1 for the next tick. State stays IDLE, so back-to-back Starts give one result per tick.
  - IDLE plus accepted op 3/13/14/15: latch operand magnitudes and sign bits, clear accumulator, set counter to WIDTH, go to RUN with Busy=1.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per tick; counter decrements. When counter reaches 1, go to FIX on the following tick.
  - FIX: apply sign correction. Product is negated if sign(X)^sign(Y). Quotient is negated if sign(X)^sign(Y); remainder takes the sign of X. Write outputs, Done=1, Busy=0, return to IDLE.
  - Latency from accept tick to Done: 1 tick for single-cycle ops, WIDTH+1 ticks for iterative ops. Busy is high for exactly WIDTH+1 ticks.
- Start while Busy=1 is ignored (not queued). Operands may change freely once an op is accepted.
- Outputs hold their value until the next completing op. Done is never high for two ticks for the same op.
- Divide by zero: quotient = all ones, remainder = X. Applies to both signed and unsigned; full latency still applies.
- Signed overflow (DIV of MIN by -1): quotient = MIN, remainder = 0.
- Flags are computed from the accepted operands and updated on the same tick as Result.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_SLL..ALU_DIVU opcode localparams
  - is_iterative(op) function
  - state encoding (IDLE, RUN, FIX)
- Sub-module alu_mc_iter holds the WIDTH-step multiply/divide datapath: accumulator, shift register, counter, sign fix.
- The top module contains the combinational single-cycle ops, output registers and FSM control.

Test Plan:
- Reset, then Start ADD X=5 Y=7 -> next tick Done=1, Result=12, Result_2=0, Equal=0, smaller=0, Busy never high.
- SLT X=0xFFFFFFFF Y=1 -> Result=1, smaller=1, bigger_equal=0. SLTU with the same operands -> Result=0, smaller=0.
- MUL X=-3 Y=5 -> Busy for 33 ticks, then Result=0xFFFFFFF1, Result_2=0xFFFFFFFF. MULU X=Y=0xFFFFFFFF -> Result=1, Result_2=0xFFFFFFFE.
- DIVU 100/7 -> Result=14, Result_2=2. DIV -7/2 -> Result=0xFFFFFFFD, Result_2=0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000, 0.
- DIV X=9 Y=0 -> Result=0xFFFFFFFF, Result_2=9 after 33 ticks. A Start ADD issued at RUN tick 10 is ignored (single Done, for the DIV).
- Assert Reset at RUN tick 5 of a MULU -> next tick all outputs 0, Busy=0, no Done. A fresh ADD 1+1 then completes with Result=2.
